seq_alu: RTL

Parametrised, registered ALU with a valid/ready handshake on both sides. It generalises the 6-bit combinational datapath to any `WIDTH`, adds zero/carry/overflow flags, and adds an iterative shift-add multiplier that takes `WIDTH` cycles. It sits between the controller and the register file: the controller issues one operation, then consumes one result.

---
 rtl/seq_alu.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier that takes WIDTH cycles per product.
package seq_alu_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_MUL  = 3'b111
  } op_e;
endpackage

module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  state_e             state;
  state_e             state_next;
  op_e                op_in;
  logic               accept;
  logic               mul_last;

  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  assign op_in     = op_e'(op);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign mul_last  = (state == MUL) && (count == CW'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)  state_next = (op_in == OP_MUL) ? MUL : DONE;
      MUL:  if (mul_last)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  always_comb begin
    add_ext   = {1'b0, a} + {1'b0, b};
    sub_ext   = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    unique case (op_in)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NAND: alu_res = ~(a & b);
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step; the full 2*WIDTH sum keeps the high half for carry.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // NOTE: the multiplier working registers are reset along with the outputs
  // so a reset mid-multiply leaves no stale partial product behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
    end else begin
      if (accept) begin
        if (op_in == OP_MUL) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          count  <= CW'(WIDTH);
        end else begin
          result   <= alu_res;
          zero     <= (alu_res == '0);
          carry    <= alu_carry;
          overflow <= alu_ovf;
        end
      end
      if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
        if (mul_last) begin
          result   <= acc_next[WIDTH-1:0];
          zero     <= (acc_next[WIDTH-1:0] == '0);
          carry    <= |acc_next[2*WIDTH-1:WIDTH];
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule
